// File: rtl/bricks_pkg.sv
// bricks_pkg: shared state encoding, keypad codes and field width for the bricks game.
package bricks_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        PAUSE = 3'd3,
        MISS  = 3'd4,
        OVER  = 3'd5,
        WIN   = 3'd6
    } state_t;
    localparam logic [3:0] KEY_NONE  = 4'h0;
    localparam logic [3:0] KEY_START = 4'hA;
    localparam logic [3:0] KEY_PAUSE = 4'hB;
    localparam int BRICK_W = 96;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: free-running modulo-DIV counter; tick is high during the last count.
module tick_gen #(
    parameter int DIV = 50
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);
    localparam int W = $clog2(DIV);
    logic [W-1:0] count_q, count_d;
    assign tick = count_q == W'(DIV - 1);
    always_comb count_d = tick ? '0 : count_q + W'(1);
    always_ff @(posedge clock) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: bricks game controller; phases the ball/plate datapath, gates
// motion with move_en and tracks lives.
module game_sequencer
    import bricks_pkg::*;
#(
    parameter int TICK_DIV    = 50,
    parameter int LIVES       = 3,
    parameter int SERVE_TICKS = 4,
    parameter int MISS_TICKS  = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [3:0]         control,
    input  logic               ball_miss,
    input  logic [BRICK_W-1:0] bricks,
    output logic               move_en,
    output logic               ball_reload,
    output logic               bricks_reload,
    output logic [2:0]         lives,
    output logic [2:0]         state,
    output logic               game_over,
    output logic               win
);
    localparam logic [2:0] LIVES_N = 3'(LIVES);
    localparam logic [7:0] SERVE_N = 8'(SERVE_TICKS);
    localparam logic [7:0] MISS_N  = 8'(MISS_TICKS);

    state_t     state_q, state_d;
    logic [2:0] lives_q, lives_d;
    logic [7:0] phase_q, phase_d, phase_inc;
    logic [3:0] prev_control_q;
    logic       move_en_q, move_en_d, ball_reload_q, ball_reload_d;
    logic       bricks_reload_q, bricks_reload_d, game_over_q, game_over_d, win_q, win_d;
    logic       tick, start_edge, pause_edge;

    tick_gen #(.DIV(TICK_DIV)) u_tick (.clock(clock), .reset(reset), .tick(tick));

    assign start_edge = control == KEY_START && prev_control_q != KEY_START;
    assign pause_edge = control == KEY_PAUSE && prev_control_q != KEY_PAUSE;
    assign phase_inc  = phase_q + 8'd1;

    always_comb begin
        state_d         = state_q;
        lives_d         = lives_q;
        phase_d         = phase_q;
        move_en_d       = 1'b0;
        ball_reload_d   = 1'b0;
        bricks_reload_d = 1'b0;
        case (state_q)
            IDLE, OVER, WIN: if (start_edge) begin
                state_d         = SERVE;
                ball_reload_d   = 1'b1;
                bricks_reload_d = 1'b1;
                lives_d         = LIVES_N;
                phase_d         = '0;
            end
            SERVE: if (tick) begin
                phase_d = phase_inc;
                if (phase_inc == SERVE_N) begin
                    state_d = PLAY;
                    phase_d = '0;
                end
            end
            // A cleared field outranks a simultaneous miss.
            PLAY: if (bricks == '0) state_d = WIN;
                else if (ball_miss && lives_q <= 3'd1) begin
                    lives_d = '0;
                    state_d = OVER;
                end else if (ball_miss) begin
                    lives_d = lives_q - 3'd1;
                    state_d = MISS;
                    phase_d = '0;
                end else if (pause_edge) state_d = PAUSE;
                else move_en_d = tick;
            PAUSE: if (pause_edge) state_d = PLAY;
            MISS: if (tick) begin
                phase_d = phase_inc;
                if (phase_inc == MISS_N) begin
                    state_d       = SERVE;
                    ball_reload_d = 1'b1;
                    phase_d       = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        game_over_d = state_d == OVER;
        win_d       = state_d == WIN;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            lives_q         <= LIVES_N;
            phase_q         <= '0;
            prev_control_q  <= KEY_NONE;
            move_en_q       <= 1'b0;
            ball_reload_q   <= 1'b0;
            bricks_reload_q <= 1'b0;
            game_over_q     <= 1'b0;
            win_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            lives_q         <= lives_d;
            phase_q         <= phase_d;
            prev_control_q  <= control;
            move_en_q       <= move_en_d;
            ball_reload_q   <= ball_reload_d;
            bricks_reload_q <= bricks_reload_d;
            game_over_q     <= game_over_d;
            win_q           <= win_d;
        end
    end

    assign move_en       = move_en_q;
    assign ball_reload   = ball_reload_q;
    assign bricks_reload = bricks_reload_q;
    assign lives         = lives_q;
    assign state         = state_q;
    assign game_over     = game_over_q;
    assign win           = win_q;
endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game controller for the bricks game.
- Sequences the ball/plate datapath through the phases idle, serve, play, pause, miss, game-over and win.
- Produces a single-cycle move-enable per game tick, plus reload pulses for the ball and brick field, and tracks remaining lives.
- Sits between the keypad decoder (control code) and the plate/ball/score blocks, all of which advance only on move_en.

Parameters:
- TICK_DIV, 50, clock cycles per game tick (100 Hz clock gives 2 Hz ticks); range 2..1023.
- LIVES, 3, lives at game start; range 1..7.
- SERVE_TICKS, 4, ticks spent in SERVE before play resumes.
- MISS_TICKS, 6, ticks spent in MISS after a lost ball.

Ports:
- clock  in  1  system clock (100 Hz domain); the only clock.
- reset  in  1  synchronous, active-high reset.
- control  in  4  keypad code from the keypad decoder; 4'h0 means no key.
- ball_miss  in  1  level, high while the ball occupies the bottom row without a plate hit.
- bricks  in  96  live brick bitmap; all-zero means the field is cleared.
- move_en  out  1  one-cycle pulse per tick while in PLAY; plate, ball and score advance only on it.
- ball_reload  out  1  one-cycle pulse that returns the ball to the serve position.
- bricks_reload  out  1  one-cycle pulse that restores the full brick field.
- lives  out  3  lives remaining.
- state  out  3  current state encoding, for display/debug.
- game_over  out  1  high while in OVER.
- win  out  1  high while in WIN.

Behaviour:
- Clocking and reset: one clock (`clock`). Reset is synchronous and active-high.
- Reset values (take effect on the first clock edge with reset=1):
  - state=IDLE, lives=LIVES.
  - tick counter=0, phase counter=0, previous-key register=0.
  - All outputs 0 except lives and state.
- Reset mid-operation behaves identically and suppresses any pending pulse.
- Tick counter:
  - Free-running 0..TICK_DIV-1 in every state; wraps to 0.
  - tick = (count==TICK_DIV-1), combinational, internal only.
- Key edges: start_edge = (control==KEY_START) and (prev_control!=KEY_START); pause_edge is the same test with KEY_PAUSE. prev_control is registered every cycle.
- All outputs are registered. Pulses appear exactly one cycle after the deciding condition and last exactly one cycle.
- IDLE:
  - On start_edge: go to SERVE, pulse ball_reload and bricks_reload, set lives=LIVES, clear phase counter.
- SERVE:
  - Phase counter increments on each tick.
  - When it reaches SERVE_TICKS on a tick: go to PLAY and clear the phase counter.
  - Keys are ignored.
- PLAY: evaluate the following in priority order each cycle.
  1. bricks==0: go to WIN.
  2. ball_miss=1 and lives==1: lives=0, go to OVER.
  3. ball_miss=1: lives decrements by 1, go to MISS.
  4. pause_edge: go to PAUSE.
  5. Otherwise move_en <= tick.
- On any transition out of PLAY, move_en is 0 in the following cycle.
- PAUSE:
  - move_en is held 0; the tick counter keeps running.
  - pause_edge returns to PLAY. start_edge is ignored.
- MISS:
  - ball_miss is ignored.
  - After MISS_TICKS ticks: go to SERVE with a ball_reload pulse. Bricks are kept.
- OVER / WIN:
  - game_over or win is held high.
  - start_edge: go to SERVE with ball_reload and bricks_reload pulses and lives=LIVES.
- Simultaneous events:
  - The last brick cleared in the same cycle as ball_miss counts as WIN.
  - A start key held continuously produces only one edge.
- lives never underflows: it decrements only when it is ≥2, or in the lives==1→OVER transition to 0.
- Undefined state encodings recover to IDLE on the next clock.

Decomposition:
- Shared package `bricks_pkg`:
  - state enum IDLE=0, SERVE=1, PLAY=2, PAUSE=3, MISS=4, OVER=5, WIN=6.
  - KEY_NONE=4'h0, KEY_START=4'hA, KEY_PAUSE=4'hB.
  - BRICK_W=96.
- One natural sub-module, `tick_gen`: parameterised modulo-TICK_DIV counter emitting tick. It is reusable by the display and VGA blocks.
- The FSM, phase counter and lives register stay in game_sequencer.

Test Plan:
- Reset, then control=4'hA for 3 cycles:
  - exactly one ball_reload and one bricks_reload pulse, one cycle after the first 4'hA cycle;
  - state=SERVE, lives=3.
- Continue with TICK_DIV=50, SERVE_TICKS=4:
  - state=PLAY after the 4th tick;
  - thereafter move_en high for 1 cycle every 50 cycles, never two consecutive.
- In PLAY, assert ball_miss=1 for 10 cycles:
  - lives 3→2 exactly once, state=MISS;
  - after 6 ticks, state=SERVE with one ball_reload and no bricks_reload.
- Three misses from lives=3: third miss gives lives=0, state=OVER, game_over=1, move_en stays 0; then control=4'hA gives SERVE, lives=3, both reload pulses.
- In PLAY, drive bricks=96'h0 and ball_miss=1 in the same cycle:
  - state=WIN, win=1, lives unchanged.
- In PLAY, pulse 4'hB: PAUSE with no move_en for 200 cycles. Pulse 4'hB again: PLAY resumes. Assert reset mid-PAUSE: IDLE with all pulses 0.
